sva_thread_sched: RTL

- Scheduler for the assertion-checker thread table. It owns up to SLOTS live assertion threads.
- On every sampled user-clock edge it walks the live threads in slot order and sends each one, one at a time, to the shared next-state evaluator over a valid/ready request and response interface.
- It writes each result back to its slot, then spawns one new thread from the start state.
- It keeps success, fail and overflow bookkeeping. Sits between the user-clock edge detector and the evaluator, in the sys_clk domain.

---
 rtl/sva_thread_sched.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sva_thread_sched.sv
// rtl/sva_thread_sched.sv - assertion-checker thread table scheduler
//
// Owns SLOTS live assertion threads. On every tick (one sampled user-clock
// rising edge) it walks the live threads in slot order, sends each one to the
// shared next-state evaluator, writes the result back, then spawns one new
// thread from the start state.
//
// Ports:
//   sys_clk, sys_rst_n      system clock, asynchronous active-low reset
//   tick                    one-cycle pulse: sampled user-clock edge
//   clr                     synchronous clear of counters and sticky flags
//   req_valid/req_ready     evaluation request handshake
//   req_state, req_slot     state and slot of the thread under evaluation
//   rsp_valid               evaluator result valid
//   rsp_active, rsp_state   thread continues, and its next state
//   rsp_succ, rsp_fail      thread reached END / failed on this step
//   busy, round_done        round in progress / end-of-round pulse
//   live_cnt                number of valid slots
//   succ_cnt, fail_cnt      saturating success / fail counters
//   overflow, tick_miss     sticky: spawn dropped / tick while busy

module sva_thread_sched #(
    parameter int SLOTS   = 8,
    parameter int STATE_W = 8,
    parameter int CNT_W   = 16,
    localparam int IDX_W  = $clog2(SLOTS),
    localparam int LIVE_W = $clog2(SLOTS + 1)
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               tick,
    input  logic               clr,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [STATE_W-1:0] req_state,
    output logic [IDX_W-1:0]   req_slot,
    input  logic               rsp_valid,
    input  logic               rsp_active,
    input  logic [STATE_W-1:0] rsp_state,
    input  logic               rsp_succ,
    input  logic               rsp_fail,
    output logic               busy,
    output logic               round_done,
    output logic [LIVE_W-1:0]  live_cnt,
    output logic [CNT_W-1:0]   succ_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               overflow,
    output logic               tick_miss
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_SPAWN,
        S_SPAWN_WAIT,
        S_DONE
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SLOTS-1:0]   snap_q, snap_d;
    logic [SLOTS-1:0]   valid_q, valid_d;
    logic [STATE_W-1:0] state_q [SLOTS];
    logic [STATE_W-1:0] state_d [SLOTS];
    logic [CNT_W-1:0]   succ_q, succ_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               ovf_q, ovf_d;
    logic               miss_q, miss_d;
    logic [LIVE_W-1:0]  live_q, live_d;

    logic               idx_last;
    logic               rsp_take;
    logic               ovf_set;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;

    assign idx_last = (idx_q == IDX_W'(SLOTS - 1));
    assign rsp_take = rsp_valid && (fsm_q == S_WAIT || fsm_q == S_SPAWN_WAIT);

    // Lowest-index invalid slot. Uses valid_q, which already holds every
    // write-back of the current round by the time SPAWN_WAIT is reached.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Round sequencing, slot write-back and request outputs.
    always_comb begin
        fsm_d      = fsm_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        valid_d    = valid_q;
        state_d    = state_q;
        ovf_set    = 1'b0;
        req_valid  = 1'b0;
        req_state  = '0;
        req_slot   = '0;
        round_done = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (tick) begin
                    // Snapshot keeps slots freed mid-round from being
                    // revisited and keeps the walk independent of updates.
                    snap_d = valid_q;
                    idx_d  = '0;
                    fsm_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (snap_q[idx_q]) begin
                    fsm_d = S_ISSUE;
                end else if (idx_last) begin
                    fsm_d = S_SPAWN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_ISSUE: begin
                // Driven purely from registers, so stable until accepted.
                req_valid = 1'b1;
                req_state = state_q[idx_q];
                req_slot  = idx_q;
                if (req_ready) begin
                    fsm_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_active) begin
                        state_d[idx_q] = rsp_state;
                    end else begin
                        valid_d[idx_q] = 1'b0;
                    end
                    if (idx_last) begin
                        fsm_d = S_SPAWN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        fsm_d = S_SCAN;
                    end
                end
            end
            S_SPAWN: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    fsm_d = S_SPAWN_WAIT;
                end
            end
            S_SPAWN_WAIT: begin
                if (rsp_valid) begin
                    if (rsp_active) begin
                        if (free_found) begin
                            valid_d[free_idx] = 1'b1;
                            state_d[free_idx] = rsp_state;
                        end else begin
                            ovf_set = 1'b1;
                        end
                    end
                    fsm_d = S_DONE;
                end
            end
            S_DONE: begin
                round_done = 1'b1;
                fsm_d      = S_IDLE;
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase
    end

    // Bookkeeping: clr wins over same-cycle increments and sets.
    always_comb begin
        succ_d = succ_q;
        fail_d = fail_q;
        ovf_d  = ovf_q | ovf_set;
        miss_d = miss_q | (tick && fsm_q != S_IDLE);
        live_d = '0;
        for (int i = 0; i < SLOTS; i++) begin
            live_d = live_d + LIVE_W'(valid_d[i]);
        end
        if (rsp_take && rsp_succ && succ_q != '1) begin
            succ_d = succ_q + CNT_W'(1);
        end
        if (rsp_take && rsp_fail && fail_q != '1) begin
            fail_d = fail_q + CNT_W'(1);
        end
        if (clr) begin
            succ_d = '0;
            fail_d = '0;
            ovf_d  = 1'b0;
            miss_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fsm_q   <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= '0;
            end
            succ_q  <= '0;
            fail_q  <= '0;
            ovf_q   <= 1'b0;
            miss_q  <= 1'b0;
            live_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            for (int i = 0; i < SLOTS; i++) begin
                state_q[i] <= state_d[i];
            end
            succ_q  <= succ_d;
            fail_q  <= fail_d;
            ovf_q   <= ovf_d;
            miss_q  <= miss_d;
            live_q  <= live_d;
        end
    end

    assign busy      = (fsm_q != S_IDLE);
    assign live_cnt  = live_q;
    assign succ_cnt  = succ_q;
    assign fail_cnt  = fail_q;
    assign overflow  = ovf_q;
    assign tick_miss = miss_q;

endmodule
